// File: rtl/cdb_arbiter.sv
// Round-robin arbiter granting one functional-unit result per cycle
// onto the registered common data bus, with flush and contention count.
module cdb_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ROB_IDX_W = 5,
  parameter int PHY_W     = 6,
  localparam int SRC_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*ROB_IDX_W-1:0] req_rob_id,
  input  logic [NUM_REQ*PHY_W-1:0]     req_rd_phy,
  input  logic [NUM_REQ*5-1:0]         req_rd_arch,
  input  logic [NUM_REQ*32-1:0]        req_rd_value,
  output logic                         cdb_valid,
  output logic [ROB_IDX_W-1:0]         cdb_rob_id,
  output logic [PHY_W-1:0]             cdb_rd_phy,
  output logic [4:0]                   cdb_rd_arch,
  output logic [31:0]                  cdb_rd_value,
  output logic [SRC_W-1:0]             cdb_src,
  output logic [31:0]                  conflict_cnt
);

  logic                 r_live;
  logic [SRC_W-1:0]     r_ptr;
  logic                 r_valid;
  logic [ROB_IDX_W-1:0] r_rob;
  logic [PHY_W-1:0]     r_phy;
  logic [4:0]           r_arch;
  logic [31:0]          r_val;
  logic [SRC_W-1:0]     r_src;
  logic [31:0]          r_cnt;

  logic                 w_found;
  logic [SRC_W-1:0]     w_win;
  logic [SRC_W-1:0]     w_nxt;
  logic                 w_xfer;
  logic                 w_multi;
  logic [ROB_IDX_W-1:0] w_rob;
  logic [PHY_W-1:0]     w_phy;
  logic [4:0]           w_arch;
  logic [31:0]          w_val;

  // Search from the pointer upward, wrapping; first valid wins.
  always_comb begin
    int s;
    s       = 0;
    w_found = 1'b0;
    w_win   = '0;
    w_nxt   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      s = int'(r_ptr) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      if (!w_found && req_valid[SRC_W'(s)]) begin
        w_found = 1'b1;
        w_win   = SRC_W'(s);
        w_nxt   = (s == NUM_REQ - 1) ? '0 : SRC_W'(s + 1);
      end
    end
  end

  always_comb begin
    w_rob  = '0;
    w_phy  = '0;
    w_arch = '0;
    w_val  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == SRC_W'(i)) begin
        w_rob  = req_rob_id[i*ROB_IDX_W +: ROB_IDX_W];
        w_phy  = req_rd_phy[i*PHY_W +: PHY_W];
        w_arch = req_rd_arch[i*5 +: 5];
        w_val  = req_rd_value[i*32 +: 32];
      end
    end
  end

  assign w_xfer    = w_found & ~flush & r_live;
  assign w_multi   = ($countones(req_valid) > 1);
  assign req_ready = w_xfer ? (NUM_REQ'(1) << w_win) : '0;

  // Grants stay off until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_live <= 1'b0;
    else      r_live <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr   <= '0;
      r_valid <= 1'b0;
      r_rob   <= '0;
      r_phy   <= '0;
      r_arch  <= '0;
      r_val   <= '0;
      r_src   <= '0;
      r_cnt   <= '0;
    end else begin
      r_valid <= w_xfer;
      if (w_xfer) begin
        r_rob  <= w_rob;
        r_phy  <= w_phy;
        r_arch <= w_arch;
        r_val  <= w_val;
        r_src  <= w_win;
        r_ptr  <= w_nxt;
      end
      if (w_multi && !flush && (r_cnt != '1))
        r_cnt <= r_cnt + 32'd1;
    end
  end

  assign cdb_valid    = r_valid;
  assign cdb_rob_id   = r_rob;
  assign cdb_rd_phy   = r_phy;
  assign cdb_rd_arch  = r_arch;
  assign cdb_rd_value = r_val;
  assign cdb_src      = r_src;
  assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized scoreboard bench for cdb_arbiter against a
// behavioural round-robin reference model.
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int RW = 5;
  localparam int PW = 6;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*RW-1:0] req_rob_id = '0;
  logic [N*PW-1:0] req_rd_phy = '0;
  logic [N*5-1:0]  req_rd_arch = '0;
  logic [N*32-1:0] req_rd_value = '0;
  logic            cdb_valid;
  logic [RW-1:0]   cdb_rob_id;
  logic [PW-1:0]   cdb_rd_phy;
  logic [4:0]      cdb_rd_arch;
  logic [31:0]     cdb_rd_value;
  logic [SW-1:0]   cdb_src;
  logic [31:0]     conflict_cnt;

  cdb_arbiter #(.NUM_REQ(N), .ROB_IDX_W(RW), .PHY_W(PW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rob_id(req_rob_id), .req_rd_phy(req_rd_phy),
    .req_rd_arch(req_rd_arch), .req_rd_value(req_rd_value),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
    .cdb_rd_phy(cdb_rd_phy), .cdb_rd_arch(cdb_rd_arch),
    .cdb_rd_value(cdb_rd_value), .cdb_src(cdb_src),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0] rob;
    logic [PW-1:0] phy;
    logic [4:0]    arch;
    logic [31:0]   val;
    int            src;
    int            cyc;
  } pkt_t;

  pkt_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  bit          pend[N];
  logic [RW-1:0] p_rob[N];
  logic [PW-1:0] p_phy[N];
  logic [4:0]    p_arch[N];
  logic [31:0]   p_val[N];
  int          m_ptr = 0;
  logic [31:0] m_cnt = 0;
  bit          m_live = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_valid[i]            = pend[i];
      req_rob_id[i*RW +: RW]  = p_rob[i];
      req_rd_phy[i*PW +: PW]  = p_phy[i];
      req_rd_arch[i*5 +: 5]   = p_arch[i];
      req_rd_value[i*32 +: 32] = p_val[i];
    end
  endtask

  // mode 0: random traffic, 1: all valid with 0x100+i, 2: no new work
  task automatic drive(input int mode);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (!pend[i]) begin
        if (mode == 0 && $urandom_range(2) != 0) begin
          pend[i]   = 1'b1;
          p_rob[i]  = RW'($urandom);
          p_phy[i]  = PW'($urandom);
          p_arch[i] = 5'($urandom);
          p_val[i]  = $urandom;
        end else if (mode == 1) begin
          pend[i]   = 1'b1;
          p_rob[i]  = RW'(i);
          p_phy[i]  = PW'(i + 8);
          p_arch[i] = 5'(i + 16);
          p_val[i]  = 32'h100 + 32'(i);
        end
      end
    end
    flush = (mode == 0) ? ($urandom_range(7) == 0) : 1'b0;
    apply();
  endtask

  always @(posedge clk) cyc++;

  // Reference model: evaluated with inputs stable before each edge.
  always @(negedge clk) begin
    int w;
    int pc;
    logic [N-1:0] er;
    pkt_t p;
    if (!rst) begin
      chk("ready_in_reset", 64'(req_ready), 64'(0));
      chk("cnt_in_reset", 64'(conflict_cnt), 64'(0));
      m_ptr  = 0;
      m_cnt  = 0;
      m_live = 0;
      sb.delete();
    end else begin
      w = -1;
      if (m_live && !flush) begin
        for (int k = 0; k < N; k++) begin
          if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        end
      end
      er = '0;
      if (w >= 0) er[w] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(er));
      chk("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
      if (w >= 0) begin
        p.rob  = p_rob[w];
        p.phy  = p_phy[w];
        p.arch = p_arch[w];
        p.val  = p_val[w];
        p.src  = w;
        p.cyc  = cyc + 1;
        sb.push_back(p);
        m_ptr   = (w + 1) % N;
        pend[w] = 1'b0;
      end
      pc = 0;
      for (int i = 0; i < N; i++) pc += int'(req_valid[i]);
      if (pc >= 2 && !flush && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      m_live = 1;
    end
  end

  // Monitor: pops the expectation due in this cycle.
  always @(negedge clk) begin
    bit ev;
    pkt_t p;
    if (!rst) begin
      chk("cdb_valid_in_reset", 64'(cdb_valid), 64'(0));
    end else begin
      ev = (sb.size() > 0) && (sb[0].cyc == cyc);
      chk("cdb_valid", 64'(cdb_valid), 64'(ev));
      if (ev) begin
        p = sb.pop_front();
        if (cdb_valid)
          chk("cdb_payload",
              64'({cdb_rob_id, cdb_rd_phy, cdb_rd_arch, cdb_rd_value, cdb_src}),
              64'({p.rob, p.phy, p.arch, p.val, SW'(p.src)}));
      end
    end
  end

  initial begin
    bit seen;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; p_rob[i] = '0; p_phy[i] = '0;
      p_arch[i] = '0; p_val[i] = '0;
    end
    #1 rst = 1'b0;
    #1;
    chk("cdb_valid_at_reset", 64'(cdb_valid), 64'(0));
    chk("cdb_src_at_reset", 64'(cdb_src), 64'(0));
    for (int c = 0; c < 4; c++) drive(1);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int c = 0; c < 12; c++) drive(1);
    for (int c = 0; c < 400; c++) drive(0);

    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      drive(0);
      seen = cdb_valid;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL mid_reset_wait: got no cdb_valid in 100 cycles");
    end
    #1 rst = 1'b0;
    #1;
    chk("async_cdb_valid", 64'(cdb_valid), 64'(0));
    chk("async_cnt", 64'(conflict_cnt), 64'(0));
    chk("async_ready", 64'(req_ready), 64'(0));
    for (int c = 0; c < 3; c++) drive(0);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int c = 0; c < 300; c++) drive(0);
    for (int c = 0; c < 20; c++) drive(2);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
